had_mult_pipe: RTL

//  Parametrised, pipelined Hadamard (element-wise) fixed-point multiplier: LANES x W-bit operands in, LANES x W-bit products out.

---
 rtl/had_pkg.sv | 26 ++
 rtl/had_lane_mul.sv | 43 ++++
 rtl/had_mult_pipe.sv | 66 ++++++
 3 files changed

// File: rtl/had_pkg.sv
// had_pkg: lane packing, rounding-constant and saturation-limit helpers shared by had_mult_pipe.
package had_pkg;
    localparam int MAXW = 64;
    // Lane 0 sits at the MSBs of a packed vector, so lane l starts at this bit.
    function automatic int lane_lsb(input int lanes, input int w, input int lane);
        return (lanes - 1 - lane) * w;
    endfunction
    function automatic logic [2*MAXW:0] round_const(input int frac, input bit rnd);
        logic [2*MAXW:0] r;
        r = '0;
        if (rnd && frac > 0) r[frac-1] = 1'b1;
        return r;
    endfunction
    function automatic logic [MAXW-1:0] sat_max(input int w, input bit sgn);
        logic [MAXW-1:0] r;
        r = '0;
        for (int i = 0; i < w; i++) r[i] = !(sgn && i == w - 1);
        return r;
    endfunction
    function automatic logic [MAXW-1:0] sat_min(input int w, input bit sgn);
        logic [MAXW-1:0] r;
        r = '0;
        r[w-1] = sgn;
        return r;
    endfunction
endpackage

// File: rtl/had_lane_mul.sv
// had_lane_mul: one lane; multiply+round feeds stage 1, shift/slice/flag feeds stage 2.
// HAD_MULT_SAT_EN selects saturation with an overflow flag instead of plain wrap.
module had_lane_mul import had_pkg::*; #(
    parameter int W      = 32,
    parameter int FRAC   = 24,
    parameter bit SIGNED = 1,
    parameter bit ROUND  = 0
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    output logic [2*W:0] prod,
    input  logic [2*W:0] p,
    output logic [W-1:0] z,
    output logic         ovf
);
    localparam int PW = 2 * W + 1;
    localparam logic [2*MAXW:0] RC_ALL = round_const(FRAC, ROUND);
    localparam logic [PW-1:0] RC = RC_ALL[PW-1:0];
    logic [PW-1:0] xe;
    logic [PW-1:0] ye;
    logic          unused_p;
    assign xe = SIGNED ? {{(W + 1){x[W-1]}}, x} : {{(W + 1){1'b0}}, x};
    assign ye = SIGNED ? {{(W + 1){y[W-1]}}, y} : {{(W + 1){1'b0}}, y};
    // Extending both operands to PW bits makes the low PW bits of the product exact for either signedness.
    assign prod = xe * ye + RC;
    assign unused_p = ^p;
`ifdef HAD_MULT_SAT_EN
    localparam int UW = W + 1 - FRAC;
    localparam logic [MAXW-1:0] MAX_ALL = sat_max(W, SIGNED);
    localparam logic [MAXW-1:0] MIN_ALL = sat_min(W, SIGNED);
    logic [W-1:0]  res;
    logic [UW-1:0] upper;
    logic          wrap;
    assign res   = p[W+FRAC-1:FRAC];
    assign upper = p[PW-1:W+FRAC];
    assign wrap  = SIGNED ? (upper != {UW{res[W-1]}}) : (upper != '0);
    assign z     = !wrap ? res : (SIGNED && p[PW-1]) ? MIN_ALL[W-1:0] : MAX_ALL[W-1:0];
    assign ovf   = wrap;
`else
    assign z   = p[W+FRAC-1:FRAC];
    assign ovf = 1'b0;
`endif
endmodule

// File: rtl/had_mult_pipe.sv
// had_mult_pipe: two-stage pipelined Hadamard fixed-point multiplier with valid/ready flow control.
// Define HAD_MULT_SAT_EN for per-lane saturation and ovf flags; otherwise results wrap and ovf is 0.
module had_mult_pipe import had_pkg::*; #(
    parameter int LANES  = 32,
    parameter int W      = 32,
    parameter int FRAC   = 24,
    parameter bit SIGNED = 1,
    parameter bit ROUND  = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [LANES*W-1:0] x,
    input  logic [LANES*W-1:0] y,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [LANES*W-1:0] z,
    output logic [LANES-1:0]   ovf
);
    localparam int PW = 2 * W + 1;
    logic                v1;
    logic                v2;
    logic                rdy1;
    logic                rdy2;
    logic [PW-1:0]       prod [LANES];
    logic [PW-1:0]       p1   [LANES];
    logic [LANES*W-1:0]  z_d;
    logic [LANES-1:0]    ovf_d;
    assign rdy2      = !v2 || out_ready;
    assign rdy1      = !v1 || rdy2;
    assign in_ready  = rdy1;
    assign out_valid = v2;
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        had_lane_mul #(.W(W), .FRAC(FRAC), .SIGNED(SIGNED), .ROUND(ROUND)) u_lane (
            .x    (x[lane_lsb(LANES, W, i) +: W]),
            .y    (y[lane_lsb(LANES, W, i) +: W]),
            .prod (prod[i]),
            .p    (p1[i]),
            .z    (z_d[lane_lsb(LANES, W, i) +: W]),
            .ovf  (ovf_d[i])
        );
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
        end else begin
            if (rdy1) v1 <= in_valid;
            if (rdy2) v2 <= v1;
        end
    end
    always_ff @(posedge clk) begin
        if (rdy1 && in_valid) p1 <= prod;
    end
    // z only moves when a real beat advances, so an empty pipe keeps showing the last result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            z   <= '0;
            ovf <= '0;
        end else if (rdy2 && v1) begin
            z   <= z_d;
            ovf <= ovf_d;
        end
    end
endmodule
